// File: rtl/ot_msg_sequencer.sv
// OT message sequencer: starts a sender-tree expansion, then reads every
// message out of the tree and streams it through a 2-entry ready/valid FIFO.
module ot_msg_sequencer #(
  parameter int D       = 3,
  parameter int NUM_MSG = 16 * (2 ** (D + 3))
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         func_in,
  input  logic [127:0] seed_in,
  input  logic [127:0] delta_in,
  output logic         tree_enable,
  output logic         tree_func,
  output logic [127:0] tree_seed,
  output logic [127:0] tree_delta,
  input  logic         tree_done,
  output logic [31:0]  msg_index,
  input  logic [127:0] tree_msg,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic         busy,
  output logic         batch_done,
  output logic [31:0]  batch_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [31:0] LAST_IDX = 32'(NUM_MSG - 1);

  state_t       state;
  logic         capture;
  logic [127:0] fifo_data [2];
  logic [1:0]   fifo_last;
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign m_valid = (count != 2'd0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_last  = fifo_last[rd_ptr];
  assign pop     = m_valid && m_ready;
  assign push    = (state == STREAM) && capture;

  // Batch FSM, two-phase tree read and output FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      capture      <= 1'b0;
      tree_enable  <= 1'b0;
      tree_func    <= 1'b0;
      tree_seed    <= '0;
      tree_delta   <= '0;
      msg_index    <= '0;
      busy         <= 1'b0;
      batch_done   <= 1'b0;
      batch_count  <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= '0;
    end else begin
      batch_done <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        capture     <= 1'b0;
        tree_enable <= 1'b0;
        busy        <= 1'b0;
        msg_index   <= '0;
        rd_ptr      <= 1'b0;
        wr_ptr      <= 1'b0;
        count       <= '0;
      end else begin
        if (push) begin
          fifo_data[wr_ptr] <= tree_msg;
          fifo_last[wr_ptr] <= (msg_index == LAST_IDX);
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
        unique case (state)
          IDLE: begin
            if (start) begin
              tree_func   <= func_in;
              tree_seed   <= seed_in;
              tree_delta  <= delta_in;
              tree_enable <= 1'b1;
              busy        <= 1'b1;
              state       <= EXPAND;
            end
          end
          EXPAND: begin
            if (tree_done) begin
              tree_enable <= 1'b0;
              msg_index   <= '0;
              capture     <= 1'b0;
              state       <= STREAM;
            end
          end
          STREAM: begin
            if (capture) begin
              capture <= 1'b0;
              if (msg_index == LAST_IDX) begin
                state <= DRAIN;
              end else begin
                msg_index <= msg_index + 32'd1;
              end
            end else if (count < 2'd2) begin
              capture <= 1'b1;
            end
          end
          DRAIN: begin
            if (pop && m_last) begin
              state       <= IDLE;
              busy        <= 1'b0;
              batch_done  <= 1'b1;
              batch_count <= batch_count + 32'd1;
              msg_index   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ot_msg_sequencer.sv
// Bench for ot_msg_sequencer: behavioural tree stand-in plus a stream
// scoreboard that predicts every message from the latched batch inputs.
module tb_ot_msg_sequencer;

  localparam int D       = 3;
  localparam int NUM_MSG = 16 * (2 ** (D + 3));

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic         func_in;
  logic [127:0] seed_in;
  logic [127:0] delta_in;
  logic         tree_enable;
  logic         tree_func;
  logic [127:0] tree_seed;
  logic [127:0] tree_delta;
  logic         tree_done;
  logic [31:0]  msg_index;
  logic [127:0] tree_msg = '0;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;
  logic         busy;
  logic         batch_done;
  logic [31:0]  batch_count;

  ot_msg_sequencer #(.D(D), .NUM_MSG(NUM_MSG)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .func_in(func_in), .seed_in(seed_in), .delta_in(delta_in),
    .tree_enable(tree_enable), .tree_func(tree_func),
    .tree_seed(tree_seed), .tree_delta(tree_delta),
    .tree_done(tree_done), .msg_index(msg_index), .tree_msg(tree_msg),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .batch_done(batch_done),
    .batch_count(batch_count)
  );

  int nchk = 0;
  int nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] model_msg(input logic [31:0] idx,
      input logic [127:0] s, input logic [127:0] d, input logic f);
    logic [127:0] v;
    v = s ^ {d[63:0], 32'hA5A5_0000, idx};
    v = {v[126:0], v[127]} ^ (f ? {4{32'h5A5A_C3C3}} : 128'd0);
    return v;
  endfunction

  // Tree stand-in: message for the held index appears one cycle later.
  always @(posedge clk)
    tree_msg <= model_msg(msg_index, tree_seed, tree_delta, tree_func);

  // Scoreboard state
  bit           mon_on = 0;
  bit           rand_ready = 0;
  int           exp_idx, done_cnt, last_cnt, run_len;
  logic [31:0]  last_idx;
  logic [127:0] cur_seed, cur_delta;
  logic         cur_func;
  bit           prev_stall;
  logic [127:0] prev_data;
  logic         prev_last;

  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = ($urandom_range(0, 99) >= 30);
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (prev_stall) begin
        nchk++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          nerr++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b want 1 %h %b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid && m_ready) begin
        nchk++;
        if (m_data !== model_msg(32'(exp_idx), cur_seed, cur_delta, cur_func) ||
            m_last !== (exp_idx == NUM_MSG - 1)) begin
          nerr++;
          $display("FAIL stream_data idx %0d: got %h last=%b want %h last=%b",
                   exp_idx, m_data, m_last,
                   model_msg(32'(exp_idx), cur_seed, cur_delta, cur_func),
                   (exp_idx == NUM_MSG - 1));
        end
        if (m_last) last_cnt++;
        exp_idx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (batch_done) done_cnt++;
      if (msg_index != last_idx) begin
        if (msg_index == last_idx + 32'd1) begin
          nchk++;
          if (run_len < 2) begin
            nerr++;
            $display("FAIL index_hold: index %0d held %0d cycles, want >=2",
                     last_idx, run_len);
          end
        end
        nchk++;
        if (msg_index > 32'(NUM_MSG - 1)) begin
          nerr++;
          $display("FAIL index_range: got %0d max %0d", msg_index, NUM_MSG - 1);
        end
        run_len  = 1;
        last_idx = msg_index;
      end else begin
        run_len++;
      end
    end
  end

  task automatic begin_batch(input logic [127:0] s, input logic [127:0] d,
                             input logic f);
    @(posedge clk);
    #1;
    seed_in = s; delta_in = d; func_in = f; start = 1'b1;
    cur_seed = s; cur_delta = d; cur_func = f;
    exp_idx = 0; done_cnt = 0; last_cnt = 0; prev_stall = 0;
    last_idx = '0; run_len = 0; mon_on = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_expand(input int n);
    repeat (n) @(posedge clk);
    #1 tree_done = 1'b1;
    @(posedge clk);
    #1 tree_done = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit to);
    to = 1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) begin
        to = 0;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #3;
    nchk++;
    if ({tree_enable, tree_func, m_valid, m_last, busy, batch_done} !== 6'd0) begin
      nerr++;
      $display("FAIL reset_flags: got %b want 000000",
               {tree_enable, tree_func, m_valid, m_last, busy, batch_done});
    end
    nchk++;
    if (tree_seed !== '0 || tree_delta !== '0 || m_data !== '0) begin
      nerr++;
      $display("FAIL reset_data: seed=%h delta=%h data=%h want 0",
               tree_seed, tree_delta, m_data);
    end
    nchk++;
    if (msg_index !== 32'd0 || batch_count !== 32'd0) begin
      nerr++;
      $display("FAIL reset_counters: idx=%0d count=%0d want 0 0",
               msg_index, batch_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int en_bad;
    bit to;
    m_ready = 1'b1;
    begin_batch(128'h1, 128'h0, 1'b0);
    nchk++;
    if (tree_seed !== 128'h1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL basic_latch: seed=%h busy=%b want 1 1", tree_seed, busy);
    end
    en_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tree_enable !== 1'b1) en_bad++;
    end
    nchk++;
    if (en_bad != 0) begin
      nerr++;
      $display("FAIL basic_enable_expand: %0d low cycles want 0", en_bad);
    end
    finish_expand(1);
    @(negedge clk);
    nchk++;
    if (tree_enable !== 1'b0 || m_valid !== 1'b0 || msg_index !== 32'd0) begin
      nerr++;
      $display("FAIL basic_t1: en=%b valid=%b idx=%0d want 0 0 0",
               tree_enable, m_valid, msg_index);
    end
    @(negedge clk);
    nchk++;
    if (m_valid !== 1'b0) begin
      nerr++;
      $display("FAIL basic_t2: valid=%b want 0", m_valid);
    end
    @(negedge clk);
    nchk++;
    if (m_valid !== 1'b1) begin
      nerr++;
      $display("FAIL basic_t3: valid=%b want 1", m_valid);
    end
    en_bad = 0;
    to = 1;
    for (int i = 0; i < 4 * NUM_MSG; i++) begin
      @(negedge clk);
      if (tree_enable !== 1'b0) en_bad++;
      if (!busy) begin
        to = 0;
        break;
      end
    end
    repeat (2) @(negedge clk);
    nchk++;
    if (to || en_bad != 0) begin
      nerr++;
      $display("FAIL basic_finish: timeout=%0d en_high=%0d want 0 0", to, en_bad);
    end
    nchk++;
    if (exp_idx != NUM_MSG || last_cnt != 1 || done_cnt != 1) begin
      nerr++;
      $display("FAIL basic_counts: msgs=%0d last=%0d done=%0d want %0d 1 1",
               exp_idx, last_cnt, done_cnt, NUM_MSG);
    end
    nchk++;
    if (batch_count !== 32'd1 || msg_index !== 32'd0) begin
      nerr++;
      $display("FAIL basic_batch_count: got %0d idx %0d want 1 0",
               batch_count, msg_index);
    end
  endtask

  task automatic test_random_ready;
    bit to;
    rand_ready = 1;
    begin_batch({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
    finish_expand($urandom_range(1, 8));
    wait_idle(8 * NUM_MSG, to);
    rand_ready = 0;
    m_ready = 1'b1;
    nchk++;
    if (to || exp_idx != NUM_MSG || last_cnt != 1 || done_cnt != 1) begin
      nerr++;
      $display("FAIL random_ready: to=%0d msgs=%0d last=%0d done=%0d want 0 %0d 1 1",
               to, exp_idx, last_cnt, done_cnt, NUM_MSG);
    end
    nchk++;
    if (batch_count !== 32'd2) begin
      nerr++;
      $display("FAIL random_batch_count: got %0d want 2", batch_count);
    end
  endtask

  task automatic test_stall;
    bit to;
    logic [31:0] hold;
    m_ready = 1'b0;
    begin_batch({$urandom, $urandom, $urandom, $urandom}, 128'hABCD, 1'b1);
    finish_expand(3);
    repeat (20) @(negedge clk);
    nchk++;
    if (m_valid !== 1'b1 || msg_index !== 32'd2 ||
        m_data !== model_msg(32'd0, cur_seed, cur_delta, cur_func)) begin
      nerr++;
      $display("FAIL stall_fill: valid=%b idx=%0d data=%h want 1 2 %h",
               m_valid, msg_index, m_data,
               model_msg(32'd0, cur_seed, cur_delta, cur_func));
    end
    hold = msg_index;
    repeat (10) @(negedge clk);
    nchk++;
    if (msg_index !== hold || exp_idx != 0) begin
      nerr++;
      $display("FAIL stall_index: idx=%0d sent=%0d want %0d 0",
               msg_index, exp_idx, hold);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_idle(4 * NUM_MSG, to);
    nchk++;
    if (to || exp_idx != NUM_MSG || done_cnt != 1 || batch_count !== 32'd3) begin
      nerr++;
      $display("FAIL stall_resume: to=%0d msgs=%0d done=%0d count=%0d want 0 %0d 1 3",
               to, exp_idx, done_cnt, batch_count, NUM_MSG);
    end
  endtask

  task automatic test_abort;
    bit to;
    bit hit;
    m_ready = 1'b1;
    begin_batch({$urandom, $urandom, $urandom, $urandom}, 128'h55, 1'b0);
    finish_expand(2);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (exp_idx == 10 && m_valid) begin
        hit = 1;
        break;
      end
    end
    nchk++;
    if (!hit) begin
      nerr++;
      $display("FAIL abort_reach: message 10 not reached, sent=%0d", exp_idx);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    mon_on = 0;
    nchk++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || tree_enable !== 1'b0 ||
        msg_index !== 32'd0 || batch_done !== 1'b0) begin
      nerr++;
      $display("FAIL abort_state: busy=%b valid=%b en=%b idx=%0d done=%b want 0",
               busy, m_valid, tree_enable, msg_index, batch_done);
    end
    nchk++;
    if (batch_count !== 32'd3 || done_cnt != 0) begin
      nerr++;
      $display("FAIL abort_count: count=%0d pulses=%0d want 3 0",
               batch_count, done_cnt);
    end
    repeat (5) @(negedge clk);
    begin_batch({$urandom, $urandom, $urandom, $urandom}, 128'h77, 1'b1);
    finish_expand(2);
    wait_idle(4 * NUM_MSG, to);
    nchk++;
    if (to || exp_idx != NUM_MSG || done_cnt != 1 || batch_count !== 32'd4) begin
      nerr++;
      $display("FAIL abort_rerun: to=%0d msgs=%0d done=%0d count=%0d want 0 %0d 1 4",
               to, exp_idx, done_cnt, batch_count, NUM_MSG);
    end
  endtask

  task automatic test_start_busy;
    bit to;
    logic [127:0] sa;
    sa = {$urandom, $urandom, $urandom, $urandom};
    m_ready = 1'b1;
    begin_batch(sa, 128'h99, 1'b0);
    finish_expand(2);
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b1; tree_done = 1'b1; seed_in = ~sa;
    @(posedge clk);
    #1;
    start = 1'b0; tree_done = 1'b0;
    nchk++;
    if (tree_seed !== sa || busy !== 1'b1) begin
      nerr++;
      $display("FAIL busy_start: seed=%h busy=%b want %h 1", tree_seed, busy, sa);
    end
    wait_idle(4 * NUM_MSG, to);
    nchk++;
    if (to || exp_idx != NUM_MSG || done_cnt != 1 || batch_count !== 32'd5) begin
      nerr++;
      $display("FAIL busy_batch: to=%0d msgs=%0d done=%0d count=%0d want 0 %0d 1 5",
               to, exp_idx, done_cnt, batch_count, NUM_MSG);
    end
    @(posedge clk);
    #1;
    start = 1'b1; abort = 1'b1; seed_in = ~sa;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    nchk++;
    if (busy !== 1'b0 || tree_enable !== 1'b0 || tree_seed !== sa) begin
      nerr++;
      $display("FAIL start_abort_idle: busy=%b en=%b seed=%h want 0 0 %h",
               busy, tree_enable, tree_seed, sa);
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    m_ready = 1'b1;
    begin_batch({$urandom, $urandom, $urandom, $urandom}, 128'h3, 1'b1);
    finish_expand(2);
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    mon_on = 0;
    #1;
    nchk++;
    if ({tree_enable, tree_func, m_valid, m_last, busy, batch_done} !== 6'd0 ||
        msg_index !== 32'd0 || batch_count !== 32'd0 ||
        tree_seed !== '0 || m_data !== '0) begin
      nerr++;
      $display("FAIL reset_mid: flags=%b idx=%0d count=%0d seed=%h data=%h want 0",
               {tree_enable, tree_func, m_valid, m_last, busy, batch_done},
               msg_index, batch_count, tree_seed, m_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nchk++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || msg_index !== 32'd0) begin
      nerr++;
      $display("FAIL reset_release: busy=%b valid=%b idx=%0d want 0 0 0",
               busy, m_valid, msg_index);
    end
    begin_batch({$urandom, $urandom, $urandom, $urandom}, 128'h4, 1'b0);
    finish_expand(2);
    wait_idle(4 * NUM_MSG, to);
    nchk++;
    if (to || exp_idx != NUM_MSG || done_cnt != 1 || batch_count !== 32'd1) begin
      nerr++;
      $display("FAIL reset_rerun: to=%0d msgs=%0d done=%0d count=%0d want 0 %0d 1 1",
               to, exp_idx, done_cnt, batch_count, NUM_MSG);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; func_in = 1'b0;
    seed_in = '0; delta_in = '0; tree_done = 1'b0; m_ready = 1'b0;
    test_reset();
    test_basic();
    test_random_ready();
    test_stall();
    test_abort();
    test_start_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
